hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: max consecutive MEM_WAIT cycles before ERROR.
REQ-002 SHALL have ports, one per line, in this order:
  clk_i  in  1  single clock, rising edge
  rst_i  in  1  asynchronous, active-low reset
  instr_op_i  in  6  opcode of instruction in IF/ID
  ifid_rs_i  in  5  rs of IF/ID instruction
  ifid_rt_i  in  5  rt of IF/ID instruction
  idex_memread_i  in  1  ID/EX instruction is a load
  idex_rt_i  in  5  load destination in ID/EX
  exmem_mem_req_i  in  1  load/store in MEM stage issuing a data-memory request
  dmem_ready_i  in  1  data memory completes the request this cycle
  branch_taken_i  in  1  branch in MEM stage resolved taken
  pc_write_o  out  1  PC load enable
  ifid_write_o  out  1  IF/ID load enable
  pipe_hold_o  out  1  hold ID/EX, EX/MEM, MEM/WB
  ifid_flush_o, idex_flush_o, exmem_flush_o  out  1 each  insert bubble
  ext_mode_o  out  2  immediate-extender mode: 00 sign, 01 zero, 10 upper (imm<<16)
  err_o  out  1  sticky memory-timeout error
  stall_cnt_o  out  16  saturating count of cycles with pc_write_o=0
  flush_cnt_o  out  16  saturating count of branch-flush events

Function
REQ-003 SHALL implement FSM states RUN, MEM_WAIT, ERROR; outputs Mealy on current state plus inputs.
REQ-004 ext_mode_o SHALL be combinational from instr_op_i in every state: 0x0C/0x0D -> 01, 0x0F -> 10, all else -> 00.
REQ-005 Load-use hazard SHALL be idex_memread_i && idex_rt_i!=0 && (idex_rt_i==ifid_rs_i || idex_rt_i==ifid_rt_i).
REQ-006 Mem-stall SHALL be exmem_mem_req_i && !dmem_ready_i.
REQ-007 RUN, priority mem-stall > branch > load-use > none.
REQ-008 RUN mem-stall: pc_write_o=0, ifid_write_o=0, pipe_hold_o=1, no flushes; next state MEM_WAIT, timeout counter cleared to 1.
REQ-009 RUN branch_taken_i: pc_write_o=1, ifid_flush_o=idex_flush_o=exmem_flush_o=1, flush_cnt_o+1; stay RUN; a simultaneous load-use is discarded.
REQ-010 RUN load-use: pc_write_o=0, ifid_write_o=0, idex_flush_o=1, pipe_hold_o=0; stay RUN (exactly one bubble, since the bubble clears idex_memread_i).
REQ-011 RUN none: pc_write_o=ifid_write_o=1, all holds/flushes 0.
REQ-012 MEM_WAIT with dmem_ready_i=0: full hold as REQ-008, timeout counter +1; when counter reaches MEM_TIMEOUT -> ERROR.
REQ-013 MEM_WAIT with dmem_ready_i=1: release (outputs per RUN rules for load-use/branch evaluated that cycle, mem-stall excluded); next RUN.
REQ-014 ERROR: pc_write_o=0, ifid_write_o=0, pipe_hold_o=1, no flushes, err_o=1; exit only by reset.
REQ-015 stall_cnt_o SHALL increment every cycle pc_write_o=0, saturating at 0xFFFF; flush_cnt_o saturates likewise.
REQ-016 branch_taken_i while in MEM_WAIT/ERROR SHALL be ignored (cannot coexist with a MEM-stage memory op).

Reset
REQ-017 rst_i=0 SHALL asynchronously force state RUN, timeout counter 0, err_o=0, stall_cnt_o=0, flush_cnt_o=0.
REQ-018 During reset combinational outputs SHALL follow RUN rules; reset mid-MEM_WAIT or in ERROR returns to RUN with counters cleared.

Structure
REQ-019 Shared package SHALL hold state encodings, EXT_SIGN/EXT_ZERO/EXT_UPPER, opcodes ANDI/ORI/LUI, MEM_TIMEOUT default.
REQ-020 One sub-module sat_counter16 (enable, clear, 16-bit saturating), instantiated twice.

Verification
REQ-021 idex_memread_i=1, idex_rt_i=8, ifid_rs_i=8 -> one cycle pc_write_o=0, idex_flush_o=1, stall_cnt_o=1; next cycle normal.
REQ-022 Load-use (rt=9 match) and branch_taken_i=1 same cycle -> three flushes, pc_write_o=1, flush_cnt_o=1, stall_cnt_o=0.
REQ-023 exmem_mem_req_i=1, dmem_ready_i low 3 cycles then high -> hold 3 cycles, release 4th, stall_cnt_o=3, state RUN.
REQ-024 MEM_TIMEOUT=4, dmem_ready_i held low -> ERROR after 4 wait cycles, err_o=1 stays; rst_i low -> err_o=0, RUN.
REQ-025 instr_op_i 0x0D -> ext_mode_o=01; 0x0F -> 10; 0x23 -> 00; idex_rt_i=0 with rs=0 -> no stall.
REQ-026 Force 65540 load-use stalls -> stall_cnt_o saturates at 0xFFFF.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states,
// immediate-extender modes, relevant opcodes and the control bundle.
package hazard_ctrl_pkg;

    localparam int unsigned STATE_W  = 2;
    localparam int unsigned EXT_W    = 2;
    localparam int unsigned OP_W     = 6;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned TMO_W    = 16;

    localparam int unsigned MEM_TIMEOUT_DEF = 255;

    localparam logic [STATE_W-1:0] ST_RUN      = 2'd0;
    localparam logic [STATE_W-1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [STATE_W-1:0] ST_ERROR    = 2'd2;

    localparam logic [EXT_W-1:0] EXT_SIGN  = 2'b00;
    localparam logic [EXT_W-1:0] EXT_ZERO  = 2'b01;
    localparam logic [EXT_W-1:0] EXT_UPPER = 2'b10;

    localparam logic [OP_W-1:0] OP_ANDI = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI  = 6'h0D;
    localparam logic [OP_W-1:0] OP_LUI  = 6'h0F;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic pipe_hold;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } ctrl_t;

    // Logical immediates zero-extend, LUI shifts up, everything else sign-extends
    function automatic logic [EXT_W-1:0] ext_mode_f(input logic [OP_W-1:0] op);
        case (op)
            OP_ANDI, OP_ORI: return EXT_ZERO;
            OP_LUI:          return EXT_UPPER;
            default:         return EXT_SIGN;
        endcase
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16
    import hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and
// data-memory wait handling with a timeout that latches an error.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [OP_W-1:0]  instr_op_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    input  logic             idex_memread_i,
    input  logic [REG_W-1:0] idex_rt_i,
    input  logic             exmem_mem_req_i,
    input  logic             dmem_ready_i,
    input  logic             branch_taken_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             pipe_hold_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             exmem_flush_o,
    output logic [EXT_W-1:0] ext_mode_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic [STATE_W-1:0] state, state_next;
    logic [TMO_W-1:0]   tmo, tmo_next, tmo_inc;
    ctrl_t              ctrl;
    logic               load_use, mem_stall;

    assign load_use  = idex_memread_i && (idex_rt_i != '0) &&
                       ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
    assign mem_stall = exmem_mem_req_i && !dmem_ready_i;
    assign tmo_inc   = tmo + TMO_W'(1);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_RUN;
            tmo   <= '0;
        end else begin
            state <= state_next;
            tmo   <= tmo_next;
        end
    end

    // Mealy control: the memory stall dominates, then branch, then load-use
    always_comb begin
        ctrl       = '0;
        state_next = state;
        tmo_next   = tmo;
        case (state)
            ST_RUN: begin
                if (mem_stall) begin
                    ctrl.pipe_hold = 1'b1;
                    state_next     = ST_MEM_WAIT;
                    tmo_next       = TMO_W'(1);
                end else if (branch_taken_i) begin
                    ctrl.pc_write    = 1'b1;
                    ctrl.ifid_write  = 1'b1;
                    ctrl.ifid_flush  = 1'b1;
                    ctrl.idex_flush  = 1'b1;
                    ctrl.exmem_flush = 1'b1;
                end else if (load_use) begin
                    ctrl.idex_flush = 1'b1;
                end else begin
                    ctrl.pc_write   = 1'b1;
                    ctrl.ifid_write = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (!dmem_ready_i) begin
                    ctrl.pipe_hold = 1'b1;
                    tmo_next       = tmo_inc;
                    if (tmo_inc >= TMO_W'(MEM_TIMEOUT)) begin
                        state_next = ST_ERROR;
                    end
                end else begin
                    state_next = ST_RUN;
                    tmo_next   = '0;
                    if (branch_taken_i) begin
                        ctrl.pc_write    = 1'b1;
                        ctrl.ifid_write  = 1'b1;
                        ctrl.ifid_flush  = 1'b1;
                        ctrl.idex_flush  = 1'b1;
                        ctrl.exmem_flush = 1'b1;
                    end else if (load_use) begin
                        ctrl.idex_flush = 1'b1;
                    end else begin
                        ctrl.pc_write   = 1'b1;
                        ctrl.ifid_write = 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                ctrl.pipe_hold = 1'b1;
            end
            default: begin
                state_next = ST_RUN;
                tmo_next   = '0;
            end
        endcase
    end

    assign pc_write_o    = ctrl.pc_write;
    assign ifid_write_o  = ctrl.ifid_write;
    assign pipe_hold_o   = ctrl.pipe_hold;
    assign ifid_flush_o  = ctrl.ifid_flush;
    assign idex_flush_o  = ctrl.idex_flush;
    assign exmem_flush_o = ctrl.exmem_flush;
    assign ext_mode_o    = ext_mode_f(instr_op_i);
    assign err_o         = (state == ST_ERROR);

    sat_counter16 u_stall_cnt (
        .clk   (clk_i),
        .rst_n (rst_i),
        .en    (!ctrl.pc_write),
        .clr   (1'b0),
        .cnt   (stall_cnt_o)
    );

    sat_counter16 u_flush_cnt (
        .clk   (clk_i),
        .rst_n (rst_i),
        .en    (ctrl.exmem_flush),
        .clr   (1'b0),
        .cnt   (flush_cnt_o)
    );

endmodule
